gbuf_responder: RTL and testbench

// - Global-buffer (gbuf) responder for special_pu: single-port DEPTH x DATA_WIDTH array answering the SPU's cen/wen/addr/din/dout port.
// - Adds a host preload port and a readback engine that streams SPU results out after spu_end, replacing bench-side memory/dump logic.
// - Sits between special_pu and the host/DMA side; buffer_sel selects the owner of the array.

---
 rtl/gbuf_responder.sv | 148 ++++++++++++++
 tb/tb_gbuf_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gbuf_responder.sv
// Global-buffer responder: shared word array for the SPU and host,
// plus a readback engine streaming words through a 2-entry FIFO.
module gbuf_responder #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  core_clk,
  input  logic                  rst_n,
  input  logic                  buffer_sel,
  input  logic                  gbuf_cen,
  input  logic                  gbuf_wen,
  input  logic [ADDR_WIDTH-1:0] gbuf_addr,
  input  logic [DATA_WIDTH-1:0] gbuf_din,
  output logic [DATA_WIDTH-1:0] gbuf_dout,
  input  logic                  host_cen,
  input  logic                  host_wen,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic [DATA_WIDTH-1:0] host_rdata,
  input  logic                  rb_start,
  input  logic [ADDR_WIDTH-1:0] rb_base_addr,
  input  logic [ADDR_WIDTH:0]   rb_len,
  output logic                  rb_valid,
  input  logic                  rb_ready,
  output logic [DATA_WIDTH-1:0] rb_data,
  output logic                  rb_busy,
  output logic                  rb_done,
  output logic                  rb_abort,
  output logic                  access_err
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] A_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   L_ONE = 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] fifo [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic [ADDR_WIDTH-1:0] rb_addr;
  logic [ADDR_WIDTH:0]   remain;

  logic                  issue;
  logic                  pop;
  logic                  spu_ok;
  logic                  host_ok;
  logic                  drop;
  logic                  we;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rd_word;

  // Ownership is exclusive, so one shared address/data path suffices.
  assign issue   = (state == RUN) && !buffer_sel && (count < 2'd2);
  assign pop     = rb_valid && rb_ready;
  assign spu_ok  = buffer_sel && !gbuf_cen;
  assign host_ok = !buffer_sel && !host_cen && !issue;
  assign drop    = (!buffer_sel && !gbuf_cen) || (!host_cen && !host_ok);
  assign we      = (spu_ok && !gbuf_wen) || (host_ok && !host_wen);
  assign acc_addr = buffer_sel ? gbuf_addr
                  : (issue ? rb_addr : host_addr);
  assign wdata   = buffer_sel ? gbuf_din : host_wdata;
  assign rd_word = mem[acc_addr];

  assign rb_valid = (count != 2'd0);
  assign rb_data  = fifo[rd_ptr];

  always_ff @(posedge core_clk) begin
    if (we) mem[acc_addr] <= wdata;
  end

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gbuf_dout  <= '0;
      host_rdata <= '0;
      fifo[0]    <= '0;
      fifo[1]    <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      rb_addr    <= '0;
      remain     <= '0;
      rb_busy    <= 1'b0;
      rb_done    <= 1'b0;
      rb_abort   <= 1'b0;
      access_err <= 1'b0;
    end else begin
      rb_done    <= 1'b0;
      rb_abort   <= 1'b0;
      access_err <= drop;
      if (spu_ok && gbuf_wen) gbuf_dout <= rd_word;
      if (host_ok && host_wen) host_rdata <= rd_word;
      if (state != IDLE && buffer_sel) begin
        state    <= IDLE;
        count    <= 2'd0;
        wr_ptr   <= 1'b0;
        rd_ptr   <= 1'b0;
        rb_busy  <= 1'b0;
        rb_abort <= 1'b1;
      end else begin
        if (issue) begin
          fifo[wr_ptr] <= rd_word;
          wr_ptr       <= !wr_ptr;
          rb_addr      <= rb_addr + A_ONE;
          remain       <= remain - L_ONE;
        end
        if (pop) rd_ptr <= !rd_ptr;
        count <= count + 2'(issue) - 2'(pop);
        unique case (state)
          IDLE: begin
            if (rb_start && !buffer_sel) begin
              if (rb_len == '0) begin
                rb_done <= 1'b1;
              end else begin
                state   <= RUN;
                rb_busy <= 1'b1;
                rb_addr <= rb_base_addr;
                remain  <= rb_len;
              end
            end
          end
          RUN: begin
            if (issue && remain == L_ONE) state <= DRAIN;
          end
          DRAIN: begin
            if (count == 2'd1 && pop) begin
              state   <= IDLE;
              rb_busy <= 1'b0;
              rb_done <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gbuf_responder.sv
// Randomized bench for gbuf_responder against a word-array and
// expected-stream queue model.
module tb_gbuf_responder;

  localparam int AW    = 12;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic          core_clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          buffer_sel;
  logic          gbuf_cen, gbuf_wen;
  logic [AW-1:0] gbuf_addr;
  logic [DW-1:0] gbuf_din, gbuf_dout;
  logic          host_cen, host_wen;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          rb_start;
  logic [AW-1:0] rb_base_addr;
  logic [AW:0]   rb_len;
  logic          rb_valid, rb_ready;
  logic [DW-1:0] rb_data;
  logic          rb_busy, rb_done, rb_abort, access_err;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] mem_m [DEPTH];

  gbuf_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .core_clk(core_clk), .rst_n(rst_n), .buffer_sel(buffer_sel),
    .gbuf_cen(gbuf_cen), .gbuf_wen(gbuf_wen),
    .gbuf_addr(gbuf_addr), .gbuf_din(gbuf_din),
    .gbuf_dout(gbuf_dout),
    .host_cen(host_cen), .host_wen(host_wen),
    .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata),
    .rb_start(rb_start), .rb_base_addr(rb_base_addr),
    .rb_len(rb_len), .rb_valid(rb_valid), .rb_ready(rb_ready),
    .rb_data(rb_data), .rb_busy(rb_busy), .rb_done(rb_done),
    .rb_abort(rb_abort), .access_err(access_err)
  );

  always #5 core_clk = ~core_clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  task automatic host_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_cen = 0; host_wen = 0; host_addr = a; host_wdata = d;
    tick();
    host_cen = 1; host_wen = 1;
    mem_m[a] = d;
  endtask

  task automatic host_rd_chk(input logic [AW-1:0] a, input string tag);
    host_cen = 0; host_wen = 1; host_addr = a;
    tick();
    host_cen = 1;
    chk(tag, host_rdata, mem_m[a]);
  endtask

  // mode 0: sink always ready; mode 1: sink ready at random 50%
  task automatic run_rb(input int base, input int len, input int mode,
                        input string tag);
    logic [DW-1:0] expq[$];
    logic [DW-1:0] held;
    logic stalled;
    int cyc, got, first, nvalid, last_hs, dones, done_cyc;
    cyc = 0; got = 0; first = -1; nvalid = 0;
    last_hs = -1; dones = 0; done_cyc = -1; stalled = 0; held = '0;
    for (int k = 0; k < len; k++) expq.push_back(mem_m[(base + k) % DEPTH]);
    rb_base_addr = base[AW-1:0];
    rb_len = len[AW:0];
    rb_start = 1;
    rb_ready = (mode == 0);
    while (dones == 0 && cyc < len * 8 + 20) begin
      tick();
      cyc++;
      rb_start = 0;
      if (cyc == 1) chk({tag, "_busy"}, rb_busy, 1);
      if (rb_done) begin dones++; done_cyc = cyc; end
      if (rb_valid) begin
        if (first < 0) first = cyc;
        nvalid++;
        if (stalled) chk({tag, "_stable"}, rb_data, held);
      end
      rb_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
      if (rb_valid && rb_ready) begin
        if (expq.size() == 0) chk({tag, "_extra"}, got, len);
        else chk({tag, "_data"}, rb_data, expq.pop_front());
        got++;
        last_hs = cyc;
        stalled = 0;
      end else begin
        stalled = rb_valid;
        held = rb_data;
      end
    end
    rb_ready = 0;
    chk({tag, "_done"}, dones, 1);
    chk({tag, "_count"}, got, len);
    chk({tag, "_donelat"}, done_cyc, last_hs + 1);
    if (mode == 0) begin
      chk({tag, "_first"}, first, 2);
      chk({tag, "_burst"}, nvalid, len);
    end
    tick();
    chk({tag, "_done1"}, rb_done, 0);
    chk({tag, "_idle"}, rb_busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int dn;
    buffer_sel = 0; gbuf_cen = 1; gbuf_wen = 1; gbuf_addr = '0;
    gbuf_din = '0; host_cen = 1; host_wen = 1; host_addr = '0;
    host_wdata = '0; rb_start = 0; rb_base_addr = '0; rb_len = '0;
    rb_ready = 0;
    tick();
    tick();
    chk("rst_gbuf_dout", gbuf_dout, 0);
    chk("rst_host_rdata", host_rdata, 0);
    chk("rst_rb_data", rb_data, 0);
    chk("rst_outs", {rb_valid, rb_busy, rb_done, rb_abort, access_err}, 0);
    @(negedge core_clk);
    rst_n = 1;
    tick();

    host_wr(0, 32'h04030201);
    for (int a = 1; a < 80; a++) host_wr(a[AW-1:0], $urandom);
    host_wr(AW'(DEPTH - 2), $urandom);
    host_wr(AW'(DEPTH - 1), $urandom);

    // SPU read after preload: one-cycle latency
    buffer_sel = 1;
    gbuf_cen = 0; gbuf_wen = 1; gbuf_addr = '0;
    chk("spu_rd_pre", gbuf_dout, 0);
    tick();
    gbuf_cen = 1;
    chk("spu_rd", gbuf_dout, 32'h04030201);
    tick();
    chk("spu_hold", gbuf_dout, 32'h04030201);

    gbuf_cen = 0; gbuf_wen = 0; gbuf_addr = 1; gbuf_din = 32'hFFFE0281;
    tick();
    gbuf_cen = 1; gbuf_wen = 1;
    mem_m[1] = 32'hFFFE0281;
    buffer_sel = 0;
    tick();
    run_rb(1, 1, 0, "rb1");
    run_rb(0, 16, 0, "rb16");
    run_rb(8, 64, 1, "rb64");
    run_rb(DEPTH - 2, 4, 0, "wrap");
    for (int r = 0; r < 3; r++)
      run_rb($urandom_range(0, 40), $urandom_range(1, 30), 1, "rnd");

    rb_len = '0; rb_start = 1;
    tick();
    rb_start = 0;
    chk("len0_done", rb_done, 1);
    chk("len0_quiet", {rb_busy, rb_valid}, 0);
    tick();
    chk("len0_pulse", rb_done, 0);

    // abort mid-stream
    rb_base_addr = '0; rb_len = 32; rb_start = 1; rb_ready = 1;
    tick();
    rb_start = 0;
    repeat (3) tick();
    chk("abort_pre", rb_valid, 1);
    buffer_sel = 1;
    tick();
    chk("abort_pulse", rb_abort, 1);
    chk("abort_valid", rb_valid, 0);
    chk("abort_busy", rb_busy, 0);
    dn = 0;
    repeat (6) begin
      tick();
      dn += rb_done + rb_valid + rb_abort;
    end
    chk("abort_after", dn, 0);
    rb_ready = 0;
    buffer_sel = 0;
    tick();

    // SPU write while host owns the array
    gbuf_cen = 0; gbuf_wen = 0; gbuf_addr = 5; gbuf_din = ~mem_m[5];
    tick();
    gbuf_cen = 1; gbuf_wen = 1;
    chk("spu_err", access_err, 1);
    chk("spu_err_hold", gbuf_dout, 32'h04030201);
    tick();
    chk("spu_err_pulse", access_err, 0);
    host_rd_chk(5, "spu_err_mem");

    // host write collides with a readback read of the same word
    rb_base_addr = 10; rb_len = 1; rb_start = 1;
    tick();
    rb_start = 0;
    host_cen = 0; host_wen = 0; host_addr = 10; host_wdata = ~mem_m[10];
    tick();
    host_cen = 1; host_wen = 1;
    chk("coll_err", access_err, 1);
    chk("coll_data", rb_data, mem_m[10]);
    rb_ready = 1;
    tick();
    rb_ready = 0;
    chk("coll_done", rb_done, 1);
    host_rd_chk(10, "coll_mem");

    // host access while SPU owns the array
    buffer_sel = 1;
    host_cen = 0; host_wen = 0; host_addr = 20; host_wdata = ~mem_m[20];
    tick();
    host_cen = 1; host_wen = 1;
    chk("host_err", access_err, 1);
    buffer_sel = 0;
    tick();
    host_rd_chk(20, "host_err_mem");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
